// File: rtl/axi_lite_regbank.sv
// AXI4-Lite slave register bank: NUM_REGS registers with byte strobes, read-only
// status registers sourced from hw_status, and SLVERR/DECERR responses.
module axi_lite_regbank #(
    parameter int                  DATA_WIDTH = 32,
    parameter int                  ADDR_WIDTH = 8,
    parameter int                  NUM_REGS   = 8,
    parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
    input  logic                           S_AXI_ACLK,
    input  logic                           S_AXI_ARESET,
    input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic                           S_AXI_AWVALID,
    output logic                           S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                           S_AXI_WVALID,
    output logic                           S_AXI_WREADY,
    output logic [1:0]                     S_AXI_BRESP,
    output logic                           S_AXI_BVALID,
    input  logic                           S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic                           S_AXI_ARVALID,
    output logic                           S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                     S_AXI_RRESP,
    output logic                           S_AXI_RVALID,
    input  logic                           S_AXI_RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]            reg_wr_pulse,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_status
);

    localparam int              STRB_W      = DATA_WIDTH / 8;
    localparam int              ADDR_LSB    = $clog2(STRB_W);
    localparam int              IDX_W       = ADDR_WIDTH - ADDR_LSB;
    localparam logic [IDX_W:0]  NREG        = (IDX_W + 1)'(NUM_REGS);
    localparam logic [1:0]      RESP_OKAY   = 2'b00;
    localparam logic [1:0]      RESP_SLVERR = 2'b10;
    localparam logic [1:0]      RESP_DECERR = 2'b11;

    // Handshake rule on every channel: a beat transfers on a rising edge where
    // VALID and READY are both 1. READY/VALID outputs are all registered, and a
    // VALID we raise stays high with stable payload until the matching READY.

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    logic                  aw_held, w_held, aw_held_n, w_held_n;
    logic [IDX_W-1:0]      aw_idx_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0]     w_strb_q;

    logic                  aw_hs, w_hs, commit;
    logic [IDX_W-1:0]      c_idx;
    logic [DATA_WIDTH-1:0] c_data;
    logic [STRB_W-1:0]     c_strb;
    logic                  c_ro;
    logic [1:0]            c_resp;

    logic                  ar_hs;
    logic [IDX_W-1:0]      r_idx;
    logic [DATA_WIDTH-1:0] rd_val;
    logic [1:0]            r_resp;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

    assign S_AXI_BVALID = (w_state == W_RESP);
    assign S_AXI_RVALID = (r_state == R_DATA);

    // A beat that arrives on the commit edge is used directly, not via its latch.
    always_comb begin
        aw_hs     = S_AXI_AWVALID && S_AXI_AWREADY;
        w_hs      = S_AXI_WVALID && S_AXI_WREADY;
        c_idx     = aw_held ? aw_idx_q : S_AXI_AWADDR[ADDR_WIDTH-1:ADDR_LSB];
        c_data    = w_held ? w_data_q : S_AXI_WDATA;
        c_strb    = w_held ? w_strb_q : S_AXI_WSTRB;
        commit    = 1'b0;
        w_next    = w_state;
        aw_held_n = aw_held;
        w_held_n  = w_held;
        case (w_state)
            W_IDLE: begin
                if ((aw_held || aw_hs) && (w_held || w_hs)) begin
                    commit    = 1'b1;
                    w_next    = W_RESP;
                    aw_held_n = 1'b0;
                    w_held_n  = 1'b0;
                end else begin
                    aw_held_n = aw_held || aw_hs;
                    w_held_n  = w_held || w_hs;
                end
            end
            W_RESP: if (S_AXI_BREADY) w_next = W_IDLE;
        endcase
        c_ro = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (c_idx == IDX_W'(i)) c_ro = RO_MASK[i];
        end
        if ({1'b0, c_idx} >= NREG) c_resp = RESP_DECERR;
        else if (c_ro)              c_resp = RESP_SLVERR;
        else                        c_resp = RESP_OKAY;
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            w_state       <= W_IDLE;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            aw_idx_q      <= '0;
            w_data_q      <= '0;
            w_strb_q      <= '0;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BRESP   <= RESP_OKAY;
            reg_wr_pulse  <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            w_state       <= w_next;
            aw_held       <= aw_held_n;
            w_held        <= w_held_n;
            S_AXI_AWREADY <= (w_next == W_IDLE) && !aw_held_n;
            S_AXI_WREADY  <= (w_next == W_IDLE) && !w_held_n;
            if (aw_hs) aw_idx_q <= S_AXI_AWADDR[ADDR_WIDTH-1:ADDR_LSB];
            if (w_hs) begin
                w_data_q <= S_AXI_WDATA;
                w_strb_q <= S_AXI_WSTRB;
            end
            if (commit) S_AXI_BRESP <= c_resp;
            reg_wr_pulse <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (commit && c_idx == IDX_W'(i) && !RO_MASK[i]) begin
                    reg_wr_pulse[i] <= 1'b1;
                    for (int b = 0; b < STRB_W; b++) begin
                        if (c_strb[b]) regs[i][b*8 +: 8] <= c_data[b*8 +: 8];
                    end
                end
            end
        end
    end

    // Reads sample the registers before this edge's write lands: pre-write value wins.
    always_comb begin
        ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
        r_next = r_state;
        case (r_state)
            R_IDLE: if (ar_hs) r_next = R_DATA;
            R_DATA: if (S_AXI_RREADY) r_next = R_IDLE;
        endcase
        r_idx  = S_AXI_ARADDR[ADDR_WIDTH-1:ADDR_LSB];
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (r_idx == IDX_W'(i)) rd_val = RO_MASK[i] ? hw_status[i*DATA_WIDTH +: DATA_WIDTH] : regs[i];
        end
        r_resp = ({1'b0, r_idx} >= NREG) ? RESP_DECERR : RESP_OKAY;
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_state       <= R_IDLE;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RDATA   <= '0;
            S_AXI_RRESP   <= RESP_OKAY;
        end else begin
            r_state       <= r_next;
            S_AXI_ARREADY <= (r_next == R_IDLE);
            if (r_state == R_IDLE && ar_hs) begin
                S_AXI_RDATA <= rd_val;
                S_AXI_RRESP <= r_resp;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        if (RO_MASK[g]) begin : g_ro
            assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = '0;
        end else begin : g_rw
            assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
        end
    end

endmodule

// File: tb/tb_axi_lite_regbank.sv
// Directed and randomized bench for axi_lite_regbank (8 x 32-bit, register 7 read-only),
// checked against a behavioural register-file model.
module tb_axi_lite_regbank;

    localparam logic [7:0] RO = 8'h80;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   aw_addr, ar_addr;
    logic         aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
    logic         ar_valid, ar_ready, r_valid, r_ready;
    logic [31:0]  w_data, r_data;
    logic [3:0]   w_strb;
    logic [1:0]   b_resp, r_resp;
    logic [255:0] reg_out, hw_status;
    logic [7:0]   reg_wr_pulse;

    int total = 0;
    int bad   = 0;

    logic [31:0] model_regs [8];
    logic [31:0] exp_q [$];

    axi_lite_regbank #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_REGS(8), .RO_MASK(RO)
    ) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
        .S_AXI_AWADDR(aw_addr), .S_AXI_AWVALID(aw_valid), .S_AXI_AWREADY(aw_ready),
        .S_AXI_WDATA(w_data), .S_AXI_WSTRB(w_strb), .S_AXI_WVALID(w_valid), .S_AXI_WREADY(w_ready),
        .S_AXI_BRESP(b_resp), .S_AXI_BVALID(b_valid), .S_AXI_BREADY(b_ready),
        .S_AXI_ARADDR(ar_addr), .S_AXI_ARVALID(ar_valid), .S_AXI_ARREADY(ar_ready),
        .S_AXI_RDATA(r_data), .S_AXI_RRESP(r_resp), .S_AXI_RVALID(r_valid), .S_AXI_RREADY(r_ready),
        .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse), .hw_status(hw_status)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] model_flat();
        logic [255:0] f;
        f = '0;
        for (int i = 0; i < 8; i++) if (!RO[i]) f[i*32 +: 32] = model_regs[i];
        return f;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 8; i++) model_regs[i] = '0;
    endtask

    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_hold);
        logic [1:0] exp_resp;
        logic [7:0] exp_pulse;
        bit aw_done, w_done, aw_fire, w_fire;
        int idx, cyc;
        idx = int'(addr) / 4;
        exp_pulse = '0;
        if (idx >= 8) exp_resp = 2'b11;
        else if (RO[idx]) exp_resp = 2'b10;
        else begin
            exp_resp = 2'b00;
            exp_pulse[idx] = 1'b1;
            for (int b = 0; b < 4; b++) if (strb[b]) model_regs[idx][b*8 +: 8] = data[b*8 +: 8];
        end
        aw_done = 0; w_done = 0; cyc = 0;
        b_ready = (b_hold == 0);
        while (!(aw_done && w_done) && cyc < 40) begin
            if (aw_done != w_done) begin
                check("wr_early_bvalid", b_valid, 1'b0);
                if (w_done) check("wready_after_latch", w_ready, 1'b0);
                else        check("awready_after_latch", aw_ready, 1'b0);
            end
            aw_valid = !aw_done && cyc >= aw_dly;
            aw_addr  = addr;
            w_valid  = !w_done && cyc >= w_dly;
            w_data   = data;
            w_strb   = strb;
            aw_fire  = aw_valid && aw_ready;
            w_fire   = w_valid && w_ready;
            step();
            if (aw_fire) aw_done = 1;
            if (w_fire)  w_done = 1;
            cyc++;
        end
        aw_valid = 0; w_valid = 0;
        check("wr_handshake_done", {aw_done, w_done}, 2'b11);
        check("bvalid_latency", b_valid, 1'b1);
        check("bresp", b_resp, exp_resp);
        check("wr_pulse", reg_wr_pulse, exp_pulse);
        check("reg_out_after_wr", reg_out, model_flat());
        if (b_hold > 0) begin
            aw_valid = 1; aw_addr = 8'h00;
            for (int k = 0; k < b_hold; k++) begin
                check("stall_bvalid", b_valid, 1'b1);
                check("stall_bresp", b_resp, exp_resp);
                check("stall_awready", aw_ready, 1'b0);
                if (k > 0) check("stall_pulse", reg_wr_pulse, 8'h00);
                step();
            end
            aw_valid = 0;
            b_ready  = 1;
        end
        step();
        check("bvalid_drop", b_valid, 1'b0);
        check("pulse_once", reg_wr_pulse, 8'h00);
        check("awready_back", aw_ready, 1'b1);
    endtask

    task automatic axi_read(input logic [7:0] addr, input int r_hold);
        logic [1:0]  exp_resp;
        logic [31:0] exp_data;
        bit fire;
        int idx, cyc;
        idx = int'(addr) / 4;
        if (idx >= 8) begin exp_resp = 2'b11; exp_q.push_back(32'h0); end
        else if (RO[idx]) begin exp_resp = 2'b00; exp_q.push_back(hw_status[idx*32 +: 32]); end
        else begin exp_resp = 2'b00; exp_q.push_back(model_regs[idx]); end
        ar_valid = 1; ar_addr = addr;
        r_ready  = (r_hold == 0);
        fire = 0; cyc = 0;
        while (!fire && cyc < 20) begin
            fire = ar_valid && ar_ready;
            step();
            cyc++;
        end
        ar_valid = 0;
        exp_data = exp_q.pop_front();
        check("rd_handshake_done", fire, 1'b1);
        check("rvalid_latency", r_valid, 1'b1);
        check("rdata", r_data, exp_data);
        check("rresp", r_resp, exp_resp);
        if (r_hold > 0) begin
            ar_valid = 1; ar_addr = 8'h00;
            for (int k = 0; k < r_hold; k++) begin
                check("stall_rvalid", r_valid, 1'b1);
                check("stall_rdata", r_data, exp_data);
                check("stall_arready", ar_ready, 1'b0);
                step();
            end
            ar_valid = 0;
            r_ready  = 1;
        end
        step();
        check("rvalid_drop", r_valid, 1'b0);
        check("arready_back", ar_ready, 1'b1);
    endtask

    initial begin
        logic [31:0] old_val, new_val;
        rst = 1; aw_addr = 0; aw_valid = 0; w_data = 0; w_strb = 0; w_valid = 0; b_ready = 1;
        ar_addr = 0; ar_valid = 0; r_ready = 1; hw_status = '0;
        model_clear();

        step(); step();
        check("rst_awready", aw_ready, 1'b0);
        check("rst_wready", w_ready, 1'b0);
        check("rst_arready", ar_ready, 1'b0);
        check("rst_bvalid", b_valid, 1'b0);
        check("rst_rvalid", r_valid, 1'b0);
        check("rst_rdata", r_data, 32'h0);
        check("rst_pulse", reg_wr_pulse, 8'h00);
        check("rst_reg_out", reg_out, 256'h0);
        rst = 0;
        step();
        check("rel_ready", {aw_ready, w_ready, ar_ready}, 3'b111);

        for (int i = 0; i < 4; i++) axi_write(8'(i * 4), 32'(i + 1), 4'hF, 0, 0, 0);
        for (int i = 0; i < 4; i++) axi_read(8'(i * 4), 0);

        axi_write(8'h08, 32'h11223344, 4'hF, 0, 0, 0);
        axi_write(8'h08, 32'hAABBCCDD, 4'b0101, 0, 0, 0);
        check("strb_merge_reg2", reg_out[95:64], 32'h11BB33DD);
        axi_read(8'h08, 0);

        axi_write(8'h10, 32'hCAFE0001, 4'hF, 2, 0, 0);
        axi_write(8'h14, 32'hCAFE0002, 4'hF, 0, 2, 0);
        axi_read(8'h10, 0);
        axi_read(8'h14, 0);

        hw_status[7*32 +: 32] = 32'hDEADBEEF;
        axi_write(8'h1C, 32'h5, 4'hF, 0, 0, 0);
        axi_read(8'h1C, 0);

        axi_write(8'h20, 32'h12345678, 4'hF, 0, 0, 0);
        axi_read(8'h24, 0);

        for (int n = 0; n < 40; n++) begin
            hw_status = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 1) == 1)
                axi_write(8'($urandom_range(0, 9) * 4 + $urandom_range(0, 3)), $urandom,
                          4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 2));
            else
                axi_read(8'($urandom_range(0, 9) * 4 + $urandom_range(0, 3)), $urandom_range(0, 2));
        end

        axi_write(8'h18, 32'h0BADF00D, 4'hF, 0, 0, 5);
        axi_read(8'h18, 5);

        old_val = model_regs[3];
        new_val = $urandom;
        aw_valid = 1; aw_addr = 8'h0C; w_valid = 1; w_data = new_val; w_strb = 4'hF;
        ar_valid = 1; ar_addr = 8'h0C; b_ready = 1; r_ready = 1;
        step();
        aw_valid = 0; w_valid = 0; ar_valid = 0;
        model_regs[3] = new_val;
        check("collide_bvalid", b_valid, 1'b1);
        check("collide_rvalid", r_valid, 1'b1);
        check("collide_rdata_prewrite", r_data, old_val);
        check("collide_reg_out", reg_out, model_flat());
        step();

        aw_valid = 1; aw_addr = 8'h04; w_valid = 1; w_data = 32'h77; w_strb = 4'hF; b_ready = 0;
        step();
        aw_valid = 0; w_valid = 0;
        model_regs[1] = 32'h77;
        check("pre_rst_bvalid", b_valid, 1'b1);
        step(); step();
        rst = 1;
        step();
        model_clear();
        check("midresp_bvalid", b_valid, 1'b0);
        check("midresp_bresp", b_resp, 2'b00);
        check("midresp_ready", {aw_ready, w_ready, ar_ready}, 3'b000);
        check("midresp_pulse", reg_wr_pulse, 8'h00);
        check("midresp_reg_out", reg_out, 256'h0);
        rst = 0; b_ready = 1;
        step();

        aw_valid = 1; aw_addr = 8'h04;
        step();
        aw_valid = 0;
        rst = 1;
        step();
        rst = 0;
        step();
        w_valid = 1; w_data = 32'h99; w_strb = 4'hF;
        step();
        w_valid = 0;
        step(); step();
        check("abandon_no_bvalid", b_valid, 1'b0);
        check("abandon_no_commit", reg_out, model_flat());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
